// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the fifo_flow_p FIFO.
//   flow_state_t : flow-control FSM encoding (FLOW_OK / FLOW_PAUSE)
//   depth_of()   : storage depth derived from the address width
package fifo_pkg;

    typedef enum logic {
        FLOW_OK    = 1'b0,
        FLOW_PAUSE = 1'b1
    } flow_state_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/fifo_ram_p.sv
// fifo_ram_p: register-array dual-port memory with synchronous write and
// synchronous registered read. The array itself is never reset; only the
// read register is cleared so the FIFO output comes up at zero.
// Ports:
//   clk, reset      : clock and synchronous active-high reset (read reg only)
//   we, waddr, wdata: write port
//   re, raddr       : read request and address
//   rdata           : registered read data, holds while re is low
module fifo_ram_p
    import fifo_pkg::*;
#(
    parameter int DW = 6,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = depth_of(AW);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_flow_p.sv
// fifo_flow_p: parametrised synchronous FIFO with hysteresis flow control.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   data_in, push    : write word and request
//   pop              : read request
//   af_th, ae_th     : almost-full set / almost-empty release thresholds
//   data_out         : registered read data (1-cycle latency), held when idle
//   valid_out        : one-cycle pulse per accepted pop
//   count            : occupancy 0..DEPTH
//   fifo_empty/full  : decoded from count
//   almost_full      : flow-control pause (hysteresis FSM)
//   almost_empty     : count <= ae_th
//   error            : one-cycle pulse for a rejected push or pop
//   error_sticky     : latched OR of error, cleared only by reset
module fifo_flow_p
    import fifo_pkg::*;
#(
    parameter int DW = 6,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] data_in,
    input  logic          push,
    input  logic          pop,
    input  logic [AW:0]   af_th,
    input  logic [AW:0]   ae_th,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic [AW:0]   count,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          error,
    output logic          error_sticky
);

    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;
    logic          req_err;
    logic [AW:0]   count_next;
    flow_state_t   state;

    // A pop frees a slot in the same cycle, so push on full is legal with it.
    // Push on empty never forwards to the pop side: there is no bypass.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != DEPTH_C) || pop_ok);
    assign req_err = (push && !push_ok) || (pop && !pop_ok);

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    fifo_ram_p #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push_ok && !reset),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (pop_ok && !reset),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            valid_out    <= 1'b0;
            error        <= 1'b0;
            error_sticky <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_next;
            valid_out    <= pop_ok;
            error        <= req_err;
            error_sticky <= error_sticky | req_err;
        end
    end

    // Flow-control FSM. Evaluated on count_next so almost_full moves on the
    // same edge as count. With overlapping thresholds PAUSE takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FLOW_OK;
        end else begin
            case (state)
                FLOW_OK: begin
                    if (count_next >= af_th) begin
                        state <= FLOW_PAUSE;
                    end
                end
                FLOW_PAUSE: begin
                    if (!(count_next >= af_th) && (count_next <= ae_th)) begin
                        state <= FLOW_OK;
                    end
                end
                default: state <= FLOW_OK;
            endcase
        end
    end

    assign almost_full  = (state == FLOW_PAUSE);
    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == DEPTH_C);
    assign almost_empty = (count <= ae_th);

endmodule

// File: tb/tb_fifo_flow_p.sv
module tb_fifo_flow_p;

    localparam int DW = 6;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW:0]   af_th = 4'd6;
    logic [AW:0]   ae_th = 4'd2;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic          error;
    logic          error_sticky;

    fifo_flow_p #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .af_th        (af_th),
        .ae_th        (ae_th),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .count        (count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .error_sticky (error_sticky)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Behavioural model: a queue of stored words plus the observable state.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout   = '0;
    bit            m_valid  = 1'b0;
    bit            m_err    = 1'b0;
    bit            m_sticky = 1'b0;
    bit            m_paused = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit po_ok, pu_ok;
        int n;
        if (reset) begin
            q.delete();
            m_dout = '0; m_valid = 1'b0; m_err = 1'b0; m_sticky = 1'b0; m_paused = 1'b0;
        end else begin
            po_ok = pop && (q.size() > 0);
            pu_ok = push && ((q.size() < DEPTH) || po_ok);
            m_err = (push && !pu_ok) || (pop && !po_ok);
            m_sticky = m_sticky | m_err;
            m_valid = po_ok;
            if (po_ok) m_dout = q.pop_front();
            if (pu_ok) q.push_back(data_in);
            n = q.size();
            if (n >= int'(af_th)) m_paused = 1'b1;
            else if (n <= int'(ae_th)) m_paused = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit pu, input bit po, input logic [DW-1:0] d);
        reset = r; push = pu; pop = po; data_in = d;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("m_data_out", 32'(data_out), 32'(m_dout));
            check("m_valid_out", 32'(valid_out), 32'(m_valid));
            check("m_count", 32'(count), 32'(q.size()));
            check("m_fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
            check("m_fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
            check("m_almost_full", 32'(almost_full), 32'(m_paused));
            check("m_almost_empty", 32'(almost_empty), 32'(q.size() <= int'(ae_th)));
            check("m_error", 32'(error), 32'(m_err));
            check("m_error_sticky", 32'(error_sticky), 32'(m_sticky));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] wrap_in[$];

    initial begin
        // Reset / idle
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        check_en = 1'b1;
        step(0, 0, 0, '0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_others", 32'({data_out, valid_out, fifo_full, almost_full, error, error_sticky}), 0);

        // Fill 0x01..0x08
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 0, DW'(k));
            check("fill_count", 32'(count), 32'(k));
            check("fill_afull", 32'(almost_full), 32'(k >= 6));
            check("fill_full", 32'(fifo_full), 32'(k == 8));
        end

        // Drain and check order; almost_full drops once count reaches 2
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, '0);
            check("drain_data", 32'(data_out), 32'(i));
            check("drain_valid", 32'(valid_out), 1);
            check("drain_afull", 32'(almost_full), 32'((8 - i) > 2));
        end

        // Underflow
        step(0, 0, 1, '0);
        check("uflow_err", 32'(error), 1);
        check("uflow_valid", 32'(valid_out), 0);
        check("uflow_sticky", 32'(error_sticky), 1);
        step(0, 0, 0, '0);
        check("uflow_pulse", 32'(error), 0);
        check("uflow_hold", 32'(data_out), 32'h08);

        // Refill then overflow
        for (int k = 0; k < 8; k++) step(0, 1, 0, DW'(6'h10 + k));
        step(0, 1, 0, 6'h3F);
        check("oflow_err", 32'(error), 1);
        check("oflow_count", 32'(count), 8);
        check("oflow_sticky", 32'(error_sticky), 1);

        // push+pop on full
        step(0, 1, 1, 6'h3E);
        check("pp_full_err", 32'(error), 0);
        check("pp_full_count", 32'(count), 8);
        check("pp_full_data", 32'(data_out), 32'h10);
        check("pp_full_valid", 32'(valid_out), 1);

        // Drain, then push+pop on empty
        for (int k = 0; k < 8; k++) step(0, 0, 1, '0);
        check("drain2_last", 32'(data_out), 32'h3E);
        step(0, 1, 1, 6'h2A);
        check("pp_empty_err", 32'(error), 1);
        check("pp_empty_count", 32'(count), 1);
        check("pp_empty_valid", 32'(valid_out), 0);

        // Wrap-around at count=3
        step(0, 1, 0, 6'h2B);
        step(0, 1, 0, 6'h2C);
        wrap_in.push_back(6'h2A); wrap_in.push_back(6'h2B); wrap_in.push_back(6'h2C);
        for (int k = 0; k < 20; k++) begin
            wrap_in.push_back(DW'(5 * k + 1));
            step(0, 1, 1, DW'(5 * k + 1));
            check("wrap_data", 32'(data_out), 32'(wrap_in[k]));
            check("wrap_valid", 32'(valid_out), 1);
            check("wrap_count", 32'(count), 3);
        end

        // Reset mid-operation at count=5 with a pop pending
        step(0, 1, 0, 6'h11);
        step(0, 1, 0, 6'h12);
        check("pre_rst_count", 32'(count), 5);
        step(1, 0, 1, '0);
        check("mrst_count", 32'(count), 0);
        check("mrst_valid", 32'(valid_out), 0);
        check("mrst_afull", 32'(almost_full), 0);
        check("mrst_sticky", 32'(error_sticky), 0);
        step(0, 0, 0, '0);

        // Threshold change: lowering af_th pauses on the next edge
        af_th = 4'd0;
        step(0, 0, 0, '0);
        check("thr_afull", 32'(almost_full), 1);
        af_th = 4'd6;
        step(0, 0, 0, '0);
        check("thr_release", 32'(almost_full), 0);

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_flow_p.md
# fifo_flow_p

Parametrised synchronous FIFO with programmable hysteresis flow control, the successor to the fixed 6-bit `fifo_c`. It buffers words between a producer and the round-robin/pop logic. It exposes occupancy, full/empty, almost-full/almost-empty with run-time thresholds, a registered output with valid, and pulse plus sticky error reporting for the state machine.

## Interface
- `DW`, 6: data width in bits.
- `AW`, 3: address width; depth `DEPTH = 2**AW`.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `data_in` input DW: word written on accepted push.
- `push` input 1: write request.
- `pop` input 1: read request.
- `af_th` input AW+1: almost-full set threshold, 0..DEPTH.
- `ae_th` input AW+1: almost-empty / release threshold, 0..DEPTH.
- `data_out` output DW: registered read data.
- `valid_out` output 1: `data_out` valid this cycle.
- `count` output AW+1: current occupancy, 0..DEPTH.
- `fifo_empty` output 1: `count == 0`.
- `fifo_full` output 1: `count == DEPTH`.
- `almost_full` output 1: flow-control pause request, with hysteresis.
- `almost_empty` output 1: `count <= ae_th`.
- `error` output 1: one-cycle pulse for a rejected request.
- `error_sticky` output 1: latched OR of `error`; cleared only by `reset`.

## Operation
- Storage is `DEPTH` x `DW`, with `wr_ptr`/`rd_ptr` of AW bits that wrap modulo DEPTH. `count` is kept as a separate AW+1 register.
- Pop accepted (`pop_ok`) when `pop && count != 0`.
- Push accepted (`push_ok`) when `push && (count != DEPTH || pop_ok)`. A push on full with a simultaneous valid pop is accepted and `count` stays unchanged.
- A push on empty with a simultaneous pop: push accepted, pop rejected. There is no bypass.
- `count_next = count + push_ok - pop_ok`.
- Error cases: `push && !push_ok`, or `pop && !pop_ok`. Either sets `error` on the next cycle. A rejected request has no effect on pointers, `count` or memory.
- Flow-control FSM with states `FLOW_OK` and `FLOW_PAUSE`; `almost_full = (state == FLOW_PAUSE)`.
  - `FLOW_OK` -> `FLOW_PAUSE` when `count_next >= af_th`.
  - `FLOW_PAUSE` -> `FLOW_OK` when `count_next <= ae_th`.
  - If both conditions hold (misprogrammed thresholds), `FLOW_PAUSE` wins.
- Thresholds are sampled every cycle. A change takes effect on the next edge using `count_next`.
- `fifo_empty`, `fifo_full` and `almost_empty` are decoded from the `count` register, so they are glitch-free and consistent with `count`.

## Timing
- Reset values:
  - Outputs: `data_out=0`, `valid_out=0`, `count=0`, `fifo_empty=1`, `fifo_full=0`, `almost_full=0`, `almost_empty=1`, `error=0`, `error_sticky=0`.
  - Internal state: `state=FLOW_OK`, pointers 0.
  - Memory contents are not reset.
- Read latency is 1. When `pop_ok` is sampled at edge N, `data_out = mem[rd_ptr]` and `valid_out=1` during cycle N+1.
- `valid_out` is a single-cycle pulse per accepted pop. Back-to-back pops give back-to-back valid words. `data_out` holds its last value while `valid_out=0`.
- Write latency is 1. A word pushed at edge N is poppable at edge N+1, with output at N+2.
- `count`, the flags, `almost_full` and `error` all update at the same edge as the operation that causes them.
- `reset` asserted mid-operation empties the FIFO on that edge. A concurrent push or pop is ignored, and `valid_out` is 0 in the following cycle.

## Structure
- Package `fifo_pkg` holds:
  - the FSM state encoding `FLOW_OK=1'b0` and `FLOW_PAUSE=1'b1`;
  - the `DEPTH` derivation helper.
- Sub-module `fifo_ram_p`, with parameters DW/AW: register-array dual-port memory. It has a synchronous write (`we`, `waddr`, `wdata`) and a synchronous registered read (`re`, `raddr`, `rdata`), and no reset on the array.
- Top level holds the pointers, `count`, the FSM, the flag decode and the error logic.

## Test plan
Use DW=6, AW=3, `af_th=6`, `ae_th=2` unless stated otherwise.
- **Reset/idle:** reset for 2 cycles, then idle -> `fifo_empty=1`, `almost_empty=1`, `count=0`, all other outputs 0.
- **Fill and order:** push 0x01..0x08 on consecutive cycles, then pop 8 times.
  - During the pushes: `almost_full` rises the cycle `count` becomes 6; `fifo_full=1` at `count=8`.
  - During the pops: `data_out` reads 0x01..0x08 with `valid_out` high for 8 consecutive cycles; `almost_full` falls when `count` reaches 2.
- **Overflow/underflow:**
  - Push on full -> `error` pulses one cycle, `count` stays 8, `error_sticky=1`.
  - Pop on empty -> `error` pulse, `valid_out=0`.
- **Simultaneous ops:**
  - push+pop on full -> no error, `count=8`, the oldest word is output.
  - push+pop on empty -> `error=1`, `count=1`, `valid_out=0`.
- **Wrap-around:** run 20 cycles of continuous push+pop at `count=3` -> pointers wrap, output sequence matches input delayed by 3 words, `count` constant at 3.
- **Reset mid-operation:** assert `reset` with `count=5` and `pop=1` -> next cycle `count=0`, `valid_out=0`, `almost_full=0`, `error_sticky=0`.
